// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the MIPS MEM stage.
interface mem_stage_if;
    logic [1:0]  wb;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [31:0] alu_in;
    logic [31:0] writedata;
    logic [4:0]  write_reg;
    logic        pcsrc;
    logic        stall;
    logic [1:0]  wb_out;
    logic [31:0] readdata_out;
    logic [31:0] aluout_out;
    logic [4:0]  write_reg_out;
    logic        align_err;
    modport master (
        output wb, branch, memread, memwrite, zero, alu_in, writedata, write_reg,
        input  pcsrc, stall, wb_out, readdata_out, aluout_out, write_reg_out, align_err
    );
    modport slave (
        input  wb, branch, memread, memwrite, zero, alu_in, writedata, write_reg,
        output pcsrc, stall, wb_out, readdata_out, aluout_out, write_reg_out, align_err
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with wait-state data memory, branch resolve and MEM/WB latch.
// Define ALIGN_CHECK_EN to turn misaligned load/store into flagged non-accesses.
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 0
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t            state;
    logic [3:0]        cnt;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              mis;
    logic              access;
    logic              load;
    logic              commit;
`ifdef ALIGN_CHECK_EN
    assign mis = (bus.memread | bus.memwrite) & (bus.alu_in[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign idx       = bus.alu_in[ADDR_W+1:2];
    assign access    = (bus.memread | bus.memwrite) & ~mis;
    assign load      = bus.memread & ~bus.memwrite & ~mis;
    assign bus.stall = (state == IDLE) ? (access && MEM_LAT != 0) : (cnt != 4'd0);
    assign commit    = ~bus.stall;
    assign bus.pcsrc = bus.branch & bus.zero;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            bus.wb_out        <= 2'b00;
            bus.readdata_out  <= 32'd0;
            bus.aluout_out    <= 32'd0;
            bus.write_reg_out <= 5'd0;
            bus.align_err     <= 1'b0;
        end else if (bus.stall) begin
            state             <= BUSY;
            cnt               <= (state == IDLE) ? 4'(MEM_LAT - 1) : cnt - 4'd1;
            bus.wb_out        <= 2'b00;
            bus.readdata_out  <= 32'd0;
            bus.aluout_out    <= 32'd0;
            bus.write_reg_out <= 5'd0;
            bus.align_err     <= 1'b0;
        end else begin
            state             <= IDLE;
            bus.wb_out        <= mis ? 2'b00 : bus.wb;
            bus.readdata_out  <= load ? mem[idx] : 32'd0;
            bus.aluout_out    <= bus.alu_in;
            bus.write_reg_out <= bus.write_reg;
            bus.align_err     <= mis;
        end
    end
    // Contents survive reset; a store only lands on its commit edge.
    always_ff @(posedge clk) begin
        if (commit && bus.memwrite && !mis) mem[idx] <= bus.writedata;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: drives a MEM_LAT=0 and a MEM_LAT=3 mem_stage with the same directed ops
// and checks both against a transaction-level model every cycle.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic [1:0]  wb;
    logic        branch, memread, memwrite, zero;
    logic [31:0] alu_in, writedata;
    logic [4:0]  write_reg;
    mem_stage_if b0();
    mem_stage_if b3();
    assign b0.wb = wb;
    assign b0.branch = branch;
    assign b0.memread = memread;
    assign b0.memwrite = memwrite;
    assign b0.zero = zero;
    assign b0.alu_in = alu_in;
    assign b0.writedata = writedata;
    assign b0.write_reg = write_reg;
    assign b3.wb = wb;
    assign b3.branch = branch;
    assign b3.memread = memread;
    assign b3.memwrite = memwrite;
    assign b3.zero = zero;
    assign b3.alu_in = alu_in;
    assign b3.writedata = writedata;
    assign b3.write_reg = write_reg;
    mem_stage #(.ADDR_W(8), .MEM_LAT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mem_stage #(.ADDR_W(8), .MEM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    int checks = 0;
    int failures = 0;
    int n0 = 0;
    int n3 = 0;
    logic run = 1'b0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: an access is stalled for the configured latency, then commits as one transaction.
    logic       acc, mis, ra;
    logic [7:0] idx;
    assign acc = memread | memwrite;
`ifdef ALIGN_CHECK_EN
    assign mis = acc && (alu_in[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign ra  = acc && !mis;
    assign idx = alu_in[9:2];
    logic [31:0] mm [2][256];
    logic [1:0]  e_wb [2];
    logic [31:0] e_rd [2];
    logic [31:0] e_alu [2];
    logic [4:0]  e_wr [2];
    logic        e_ae [2];
    int          s [2];
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                s[d] <= 0;
                e_wb[d] <= 2'b00; e_rd[d] <= 32'd0; e_alu[d] <= 32'd0; e_wr[d] <= 5'd0; e_ae[d] <= 1'b0;
            end else if (ra && s[d] < (d == 1 ? 3 : 0)) begin
                s[d] <= s[d] + 1;
                e_wb[d] <= 2'b00; e_rd[d] <= 32'd0; e_alu[d] <= 32'd0; e_wr[d] <= 5'd0; e_ae[d] <= 1'b0;
            end else begin
                s[d] <= 0;
                e_wb[d] <= mis ? 2'b00 : wb;
                e_rd[d] <= (memread && !memwrite && !mis) ? mm[d][idx] : 32'd0;
                e_alu[d] <= alu_in;
                e_wr[d] <= write_reg;
                e_ae[d] <= mis;
                if (memwrite && !mis) mm[d][idx] <= writedata;
            end
        end
    end
    always @(negedge clk) begin
        if (run) begin
            if (b0.stall) n0++;
            if (b3.stall) n3++;
            chk("u0.stall", b0.stall, 1'b0);
            chk("u3.stall", b3.stall, ra && s[1] < 3);
            chk("u0.pcsrc", b0.pcsrc, branch & zero);
            chk("u3.pcsrc", b3.pcsrc, branch & zero);
            chk("u0.wb_out", b0.wb_out, e_wb[0]);
            chk("u3.wb_out", b3.wb_out, e_wb[1]);
            chk("u0.readdata_out", b0.readdata_out, e_rd[0]);
            chk("u3.readdata_out", b3.readdata_out, e_rd[1]);
            chk("u0.aluout_out", b0.aluout_out, e_alu[0]);
            chk("u3.aluout_out", b3.aluout_out, e_alu[1]);
            chk("u0.write_reg_out", b0.write_reg_out, e_wr[0]);
            chk("u3.write_reg_out", b3.write_reg_out, e_wr[1]);
            chk("u0.align_err", b0.align_err, e_ae[0]);
            chk("u3.align_err", b3.align_err, e_ae[1]);
        end
    end
    task automatic drive(input logic [1:0] w, input logic br, input logic z, input logic mr, input logic mw,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        wb = w; branch = br; zero = z; memread = mr; memwrite = mw;
        alu_in = a; writedata = wd; write_reg = r;
    endtask
    // Hold the op until the slower DUT has committed it.
    task automatic hold();
        #1;
        repeat (ra ? 4 : 1) @(posedge clk);
        #2;
    endtask
    task automatic op(input logic [1:0] w, input logic br, input logic z, input logic mr, input logic mw,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        drive(w, br, z, mr, mw, a, wd, r);
        hold();
    endtask
    int base;
    initial begin
        drive(2'b00, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1 rst = 1'b1;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset.wb_out", b3.wb_out, 2'b00);
        chk("reset.stall", b3.stall, 1'b0);
        op(2'b00, 0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0);
        op(2'b11, 0, 0, 1, 0, 32'h10, 32'd0, 5'd9);
        chk("t1.u0.readdata", b0.readdata_out, 32'hDEADBEEF);
        chk("t1.u3.readdata", b3.readdata_out, 32'hDEADBEEF);
        chk("t1.u3.wb_out", b3.wb_out, 2'b11);
        chk("t1.u3.write_reg", b3.write_reg_out, 5'd9);
        base = n3;
        op(2'b10, 0, 0, 1, 0, 32'h10, 32'd0, 5'd4);
        chk("t2.stall_cycles", n3 - base, 3);
        chk("t2.readdata", b3.readdata_out, 32'hDEADBEEF);
        base = n3;
        op(2'b10, 0, 0, 1, 0, 32'h10, 32'd0, 5'd5);
        chk("t2.b2b_stall_cycles", n3 - base, 3);
        drive(2'b10, 1, 1, 0, 0, 32'h12345678, 32'd0, 5'd3);
        #1 chk("t3.pcsrc_taken", b3.pcsrc, 1'b1);
        hold();
        chk("t3.aluout", b3.aluout_out, 32'h12345678);
        drive(2'b10, 1, 0, 0, 0, 32'h0BADF00D, 32'd0, 5'd3);
        #1 chk("t3.pcsrc_not_taken", b0.pcsrc, 1'b0);
        hold();
        chk("t3.aluout2", b0.aluout_out, 32'h0BADF00D);
        op(2'b00, 0, 0, 0, 1, 32'h20, 32'h5555, 5'd0);
        drive(2'b00, 0, 0, 0, 1, 32'h20, 32'h1234, 5'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1 chk("t4.stall", b3.stall, 1'b0);
        chk("t4.aluout", b3.aluout_out, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        op(2'b11, 0, 0, 1, 0, 32'h20, 32'd0, 5'd7);
        chk("t4.u3.old_value", b3.readdata_out, 32'h5555);
        chk("t4.u0.committed", b0.readdata_out, 32'h1234);
        op(2'b00, 0, 0, 0, 1, 32'h0, 32'hA5, 5'd0);
        op(2'b11, 0, 0, 1, 0, 32'h400, 32'd0, 5'd1);
        chk("t5.wrap", b3.readdata_out, 32'hA5);
        op(2'b11, 0, 0, 1, 1, 32'h40, 32'h77, 5'd2);
        chk("t5.both_readdata", b3.readdata_out, 32'd0);
        op(2'b11, 0, 0, 1, 0, 32'h40, 32'd0, 5'd2);
        chk("t5.both_stored", b3.readdata_out, 32'h77);
        base = n3;
        op(2'b11, 0, 0, 0, 1, 32'h13, 32'hBAD, 5'd6);
`ifdef ALIGN_CHECK_EN
        chk("t6.no_stall", n3 - base, 0);
        chk("t6.align_err", b3.align_err, 1'b1);
        chk("t6.wb_out", b3.wb_out, 2'b00);
        chk("t6.aluout", b3.aluout_out, 32'h13);
`else
        chk("t6.stall", n3 - base, 3);
        chk("t6.align_err", b3.align_err, 1'b0);
`endif
        op(2'b11, 0, 0, 1, 0, 32'h10, 32'd0, 5'd6);
        chk("t6.load_align_err", b3.align_err, 1'b0);
`ifdef ALIGN_CHECK_EN
        chk("t6.mem_unchanged", b3.readdata_out, 32'hDEADBEEF);
`else
        chk("t6.mem_written", b3.readdata_out, 32'hBAD);
`endif
        op(2'b00, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        chk("t1.u0.never_stalled", n0, 0);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
